// File: rtl/glyph_pkg.sv
// Shared definitions for the RGB value glyph engine: glyph geometry,
// the blank code, the conversion FSM states and the 16x16 digit glyph table.
package glyph_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  localparam logic [3:0] BLANK_CODE = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD_CH, SHIFT, COMMIT} state_t;

  // Stroke patterns used to build the seven-segment style digits.
  localparam logic [GLYPH_W-1:0] SEG_H = 16'h7FFE;  // horizontal bar
  localparam logic [GLYPH_W-1:0] SEG_L = 16'h6000;  // left vertical stroke
  localparam logic [GLYPH_W-1:0] SEG_R = 16'h0006;  // right vertical stroke

  // Segment set {g,f,e,d,c,b,a} per code; codes above 9 light nothing.
  function automatic logic [6:0] seg_of(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Glyph table: one GLYPH_W-bit row for each (code, row) pair.
  // Rows 0-1 top bar, 2-6 upper strokes, 7-8 middle bar, 9-13 lower strokes,
  // 14-15 bottom bar. The 7 uses a slanted stroke instead.
  function automatic logic [GLYPH_W-1:0] glyph_bits(input logic [3:0] code,
                                                    input logic [3:0] row);
    logic [6:0]         s;
    logic [GLYPH_W-1:0] r;
    s = seg_of(code);
    r = '0;
    if (code == 4'd7) begin
      if (row <= 4'd2)       r = 16'hFFFF;
      else if (row <= 4'd5)  r = 16'h0007;
      else if (row <= 4'd8)  r = 16'h0038;
      else if (row <= 4'd11) r = 16'h01C0;
      else                   r = 16'h0E00;
    end else begin
      if (row <= 4'd1)       r = s[0] ? SEG_H : '0;
      else if (row <= 4'd6)  r = (s[5] ? SEG_L : '0) | (s[1] ? SEG_R : '0);
      else if (row <= 4'd8)  r = s[6] ? SEG_H : '0;
      else if (row <= 4'd13) r = (s[4] ? SEG_L : '0) | (s[2] ? SEG_R : '0);
      else                   r = s[3] ? SEG_H : '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// Registered digit glyph ROM addressed by {code,row}; one-cycle read latency.
// Output holds its last value while en is low.
module glyph_rom
  import glyph_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         code,
  input  logic [3:0]         row,
  output logic [GLYPH_W-1:0] data
);

  // Registered table read; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst)     data <= '0;
    else if (en) data <= glyph_bits(code, row);
  end

endmodule

// File: rtl/rgb_value_glyph_engine.sv
// Converts NUM_CH channel values to BCD digits with a sequential double-dabble
// engine and serves glyph rows for (channel, digit, row) lookups through a
// two-stage pipeline. Digit registers change only in COMMIT, all at once.
// Optional: define LEAD_ZERO_BLANK_EN to store leading zeros as blank codes.
module rgb_value_glyph_engine
  import glyph_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int VAL_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [NUM_CH*VAL_W-1:0]   value_in,
  output logic                      busy,
  output logic                      conv_done,
  input  logic                      req_valid,
  input  logic [$clog2(NUM_CH)-1:0] req_ch,
  input  logic [$clog2(DIGITS)-1:0] req_dig,
  input  logic [$clog2(GLYPH_H)-1:0] req_row,
  output logic                      row_valid,
  output logic [GLYPH_W-1:0]        glyph_row
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(VAL_W);
  localparam int BCD_W = DIGITS * 4;

  state_t                    state_reg, state_next;
  logic [NUM_CH*VAL_W-1:0]   shadow_reg;
  logic [CH_W-1:0]           ch_reg;
  logic [CNT_W-1:0]          bit_cnt_reg;
  logic [VAL_W-1:0]          sh_reg;
  logic [BCD_W-1:0]          bcd_reg, bcd_adj, bcd_shift;
  logic [BCD_W-1:0]          temp_reg [NUM_CH];
  logic [NUM_CH*BCD_W-1:0]   digits_flat;
  logic                      last_bit, last_ch;

  logic                      s1_valid_reg;
  logic [3:0]                s1_code_reg;
  logic [3:0]                s1_row_reg;
  logic [3:0]                sel_code;
  logic                      row_valid_reg;

  assign last_bit = (int'(bit_cnt_reg) == VAL_W - 1);
  assign last_ch  = (int'(ch_reg) == NUM_CH - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and status outputs; load is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    conv_done  = 1'b0;
    case (state_reg)
      IDLE:    if (load) state_next = LOAD_CH;
      LOAD_CH: begin
        busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = last_ch ? COMMIT : LOAD_CH;
      end
      COMMIT: begin
        conv_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the value MSB.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_reg[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_reg[d*4 +: 4] + 4'd3;
    end
    bcd_shift    = bcd_adj << 1;
    bcd_shift[0] = sh_reg[VAL_W-1];
  end

  // Conversion datapath: capture, per-channel load, shift and temp store.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg  <= '0;
      ch_reg      <= '0;
      bit_cnt_reg <= '0;
      sh_reg      <= '0;
      bcd_reg     <= '0;
      for (int c = 0; c < NUM_CH; c++) temp_reg[c] <= '0;
    end else begin
      case (state_reg)
        IDLE: if (load) begin
          shadow_reg <= value_in;
          ch_reg     <= '0;
        end
        LOAD_CH: begin
          bcd_reg     <= '0;
          sh_reg      <= shadow_reg[ch_reg*VAL_W +: VAL_W];
          bit_cnt_reg <= '0;
        end
        SHIFT: begin
          bcd_reg     <= bcd_shift;
          sh_reg      <= sh_reg << 1;
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          if (last_bit) begin
            temp_reg[ch_reg] <= bcd_shift;
            if (!last_ch) ch_reg <= ch_reg + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [BCD_W-1:0] commit_code;
      logic [BCD_W-1:0] digits_reg;
`ifdef LEAD_ZERO_BLANK_EN
      // Blank every zero digit above the most significant nonzero one; units stays.
      always_comb begin : blank_lead
        logic nz;
        nz          = 1'b0;
        commit_code = temp_reg[gi];
        for (int d = DIGITS - 1; d >= 1; d--) begin
          if (temp_reg[gi][d*4 +: 4] != 4'd0) nz = 1'b1;
          if (!nz) commit_code[d*4 +: 4] = BLANK_CODE;
        end
      end
`else
      assign commit_code = temp_reg[gi];
`endif
      // Visible digits: all channels update on the COMMIT edge together.
      always_ff @(posedge clk) begin
        if (rst)                    digits_reg <= '0;
        else if (state_reg == COMMIT) digits_reg <= commit_code;
      end
      assign digits_flat[gi*BCD_W +: BCD_W] = digits_reg;
    end
  endgenerate

  // Lookup stage 1 code select; out-of-range channel or digit shows blank.
  always_comb begin
    sel_code = BLANK_CODE;
    if (int'(req_ch) < NUM_CH && int'(req_dig) < DIGITS)
      sel_code = digits_flat[(int'(req_ch)*DIGITS + int'(req_dig))*4 +: 4];
  end

  // Lookup stage 1 register and stage 2 valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_code_reg   <= '0;
      s1_row_reg    <= '0;
      row_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg  <= req_valid;
      row_valid_reg <= s1_valid_reg;
      if (req_valid) begin
        s1_code_reg <= sel_code;
        s1_row_reg  <= req_row;
      end
    end
  end

  glyph_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (s1_valid_reg),
    .code (s1_code_reg),
    .row  (s1_row_reg),
    .data (glyph_row)
  );

  assign row_valid = row_valid_reg;

endmodule

// File: tb/tb_rgb_value_glyph_engine.sv
// Self-checking bench for rgb_value_glyph_engine: reset behaviour, conversion
// timing, table-driven pipelined glyph lookups and multi-cycle corner cases.
// Honours LEAD_ZERO_BLANK_EN when defined for the build.
module tb_rgb_value_glyph_engine;

  localparam int N = 16;
`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    int          ch;
    int          dig;
    int          row;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, load, req_valid, busy, conv_done, row_valid;
  logic [23:0] value_in;
  logic [1:0]  req_ch, req_dig;
  logic [3:0]  req_row;
  logic [15:0] glyph_row;
  int          n_pass = 0;
  int          n_total = 0;
  vec_t        vecs [N];

  always #5 clk = ~clk;

  rgb_value_glyph_engine dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value_in  (value_in),
    .busy      (busy),
    .conv_done (conv_done),
    .req_valid (req_valid),
    .req_ch    (req_ch),
    .req_dig   (req_dig),
    .req_row   (req_row),
    .row_valid (row_valid),
    .glyph_row (glyph_row)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Single isolated lookup: request in one cycle, result two cycles later.
  task automatic lookup(input int ch, input int dig, input int row,
                        input logic [15:0] exp, input string nm);
    req_valid = 1'b1;
    req_ch    = 2'(ch);
    req_dig   = 2'(dig);
    req_row   = 4'(row);
    tick;
    req_valid = 1'b0;
    tick;
    $display("lookup %s ch=%0d dig=%0d row=%0d valid=%b row=%h", nm, ch, dig, row,
             row_valid, glyph_row);
    check({nm, "_valid"}, 32'(row_valid), 32'd1);
    check({nm, "_row"}, 32'(glyph_row), 32'(exp));
  endtask

  initial begin : main
    int cnt;
    bit seen;

    // Lookups after the first conversion {B=7, G=128, R=255}.
    vecs[0]  = '{2, 0, 0,  16'hFFFF};
    vecs[1]  = '{2, 0, 3,  16'h0007};
    vecs[2]  = '{2, 0, 12, 16'h0E00};
    vecs[3]  = '{2, 0, 7,  16'h0038};
    vecs[4]  = '{2, 2, 0,  LZB ? 16'h0000 : 16'h7FFE};
    vecs[5]  = '{2, 1, 3,  LZB ? 16'h0000 : 16'h6006};
    vecs[6]  = '{0, 2, 3,  16'h0006};
    vecs[7]  = '{0, 2, 10, 16'h6000};
    vecs[8]  = '{0, 1, 3,  16'h6000};
    vecs[9]  = '{0, 0, 10, 16'h0006};
    vecs[10] = '{1, 2, 3,  16'h0006};
    vecs[11] = '{1, 0, 7,  16'h7FFE};
    vecs[12] = '{1, 1, 15, 16'h7FFE};
    vecs[13] = '{3, 0, 0,  16'h0000};
    vecs[14] = '{0, 3, 0,  16'h0000};
    vecs[15] = '{1, 2, 7,  16'h0000};

    rst = 1'b1; load = 1'b0; value_in = '0;
    req_valid = 1'b0; req_ch = '0; req_dig = '0; req_row = '0;
    tick;
    tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_conv_done", 32'(conv_done), 32'd0);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_glyph_row", 32'(glyph_row), 32'd0);
    rst = 1'b0;
    tick;

    // Reset in busy cycle 10 aborts the conversion without a conv_done.
    value_in = {8'd7, 8'd128, 8'd255};
    load = 1'b1;
    tick;
    load = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (conv_done) seen = 1'b1;
      tick;
    end
    $display("abort: conv_done seen=%b", seen);
    check("abort_no_conv_done", 32'(seen), 32'd0);
    for (int c = 0; c < 3; c++)
      for (int d = 0; d < 3; d++)
        lookup(c, d, 0, 16'h7FFE, "after_abort");

    // Full conversion timing: 27 busy cycles then conv_done with busy low.
    value_in = {8'd7, 8'd128, 8'd255};
    load = 1'b1;
    tick;
    load = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick;
    end
    $display("conv1: busy cycles=%0d conv_done=%b busy=%b", cnt, conv_done, busy);
    check("conv1_busy_cycles", 32'(cnt), 32'd27);
    check("conv1_conv_done", 32'(conv_done), 32'd1);
    tick;
    check("conv1_done_pulse", 32'(conv_done), 32'd0);

    // Back-to-back table lookups; each result lands two cycles after its request.
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        req_valid = 1'b1;
        req_ch    = 2'(vecs[i].ch);
        req_dig   = 2'(vecs[i].dig);
        req_row   = 4'(vecs[i].row);
      end else begin
        req_valid = 1'b0;
      end
      tick;
      if (i >= 1) begin
        $display("vec %0d ch=%0d dig=%0d row=%0d valid=%b row=%h", i - 1, vecs[i-1].ch,
                 vecs[i-1].dig, vecs[i-1].row, row_valid, glyph_row);
        check($sformatf("vec%0d_valid", i - 1), 32'(row_valid), 32'd1);
        check($sformatf("vec%0d_row", i - 1), 32'(glyph_row), 32'(vecs[i-1].exp));
      end
    end
    tick;
    check("idle_row_valid", 32'(row_valid), 32'd0);
    check("idle_row_hold", 32'(glyph_row), 32'(vecs[N-1].exp));

    // Second conversion {B=200, G=42, R=0}; a load mid-conversion is ignored
    // and lookups keep returning the previous digits.
    value_in = {8'd200, 8'd42, 8'd0};
    load = 1'b1;
    tick;
    load = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        load = 1'b1;
        value_in = {8'd1, 8'd1, 8'd1};
      end
      if (cnt == 6) load = 1'b0;
      if (cnt == 10) begin
        req_valid = 1'b1; req_ch = 2'd0; req_dig = 2'd0; req_row = 4'd10;
      end
      if (cnt == 11) req_valid = 1'b0;
      if (cnt == 12) begin
        $display("mid-conv lookup valid=%b row=%h", row_valid, glyph_row);
        check("midconv_valid", 32'(row_valid), 32'd1);
        check("midconv_old_row", 32'(glyph_row), 32'h0006);
      end
      tick;
    end
    $display("conv2: busy cycles=%0d conv_done=%b", cnt, conv_done);
    check("conv2_busy_cycles", 32'(cnt), 32'd27);
    check("conv2_conv_done", 32'(conv_done), 32'd1);

    // Lookup whose stage 1 falls in the COMMIT cycle still sees the old digits.
    lookup(0, 0, 10, 16'h0006, "commit_cycle");
    check("conv2_no_restart", 32'(busy), 32'd0);

    lookup(0, 0, 10, 16'h6006, "r0_units");
    lookup(0, 2, 0, LZB ? 16'h0000 : 16'h7FFE, "r0_hundreds");
    lookup(0, 1, 0, LZB ? 16'h0000 : 16'h7FFE, "r0_tens");
    lookup(1, 1, 3, 16'h6006, "g42_tens");
    lookup(1, 2, 3, LZB ? 16'h0000 : 16'h6006, "g42_hundreds");
    lookup(2, 2, 3, 16'h0006, "b200_hundreds");
    lookup(2, 0, 15, 16'h7FFE, "b200_units");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
